apb_reg_subordinate: RTL

- APB completer (responder) register bank that terminates APB transfers issued by the NoC-to-APB bridge manager.
- Provides one read-only ID register, one read-only completed-transfer counter and (NUM_REGS-2) read/write scratch registers.
- Inserts a fixed number of wait states and signals errors through PSLVERR.
- Serves as the bring-up and verification endpoint for the NI/FIFO/APB-manager path.

---
 rtl/apb_reg_subordinate.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/apb_reg_subordinate.sv
// ---------------------------------------------------------------------------
// apb_reg_subordinate
//
// APB completer register bank used as the bring-up endpoint behind the
// NoC-to-APB bridge. Register map (32-bit words, index = PADDR[ADDR_W-1:2]):
//   0            : read-only ID (ID_VALUE)
//   1            : read-only count of completed non-error transfers
//   2..NUM_REGS-1: read/write scratch registers with byte strobes
// Every transfer is stretched by WAIT_STATES PREADY-low access cycles.
// Misaligned addresses, out-of-range indices and writes to the read-only
// words complete with PSLVERR=1 and leave all state untouched.
//
// Ports:
//   PCLK     in   clock, all state on the rising edge
//   PRESETn  in   asynchronous active-low reset
//   PSEL     in   subordinate select
//   PENABLE  in   access phase indicator
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   byte address [ADDR_W]
//   PWDATA   in   write data [32]
//   PSTRB    in   write byte enables [4]
//   PREADY   out  transfer completion (high only in READY)
//   PRDATA   out  read data [32], zero outside a successful read
//   PSLVERR  out  transfer error, only meaningful while PREADY=1
// ---------------------------------------------------------------------------
module apb_reg_subordinate #(
    parameter int          ADDR_W      = 32,
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    input  logic [3:0]        PSTRB,
    output logic              PREADY,
    output logic [31:0]       PRDATA,
    output logic              PSLVERR
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int NUM_SCR = NUM_REGS - 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_next;

    logic [ADDR_W-1:0]  r_addr;
    logic               r_write;
    logic [31:0]        r_wdata;
    logic [3:0]         r_strb;

    logic [31:0]        r_counter;
    logic [31:0]        r_scratch [NUM_SCR];
    logic [31:0]        r_prdata;
    logic               r_pslverr;

    logic               w_setup;
    logic               w_enter_ready;
    logic [ADDR_W-1:0]  w_dec_addr;
    logic               w_dec_write;
    logic [IDX_W-1:0]   w_dec_idx;
    logic [IDX_W-1:0]   w_wr_idx;
    logic               w_err;
    logic [31:0]        w_rd_val;
    logic               w_commit;
    logic [31:0]        w_wmask;

    // A setup phase is only recognised from IDLE; a stray PENABLE is ignored.
    assign w_setup = (r_state == S_IDLE) && PSEL && !PENABLE;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_enter_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_setup) begin
                    if (WAIT_STATES == 0) begin
                        w_state_next  = S_READY;
                        w_enter_ready = 1'b1;
                    end else begin
                        w_state_next = S_WAIT;
                        w_cnt_next   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (!PSEL) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_state_next  = S_READY;
                    w_enter_ready = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_READY: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Setup capture
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
        end else if (w_setup) begin
            r_addr  <= PADDR;
            r_write <= PWRITE;
            r_wdata <= PWDATA;
            r_strb  <= PSTRB;
        end
    end

    // ------------------------------------------------------------------
    // Decode. With zero wait states READY is entered straight from the
    // setup cycle, before the capture registers are loaded, so the decode
    // looks at the live bus while in IDLE and at the captured copy later.
    // ------------------------------------------------------------------
    assign w_dec_addr  = (r_state == S_IDLE) ? PADDR  : r_addr;
    assign w_dec_write = (r_state == S_IDLE) ? PWRITE : r_write;
    assign w_dec_idx   = w_dec_addr[ADDR_W-1:2];
    assign w_wr_idx    = r_addr[ADDR_W-1:2];

    assign w_err = (w_dec_addr[1:0] != 2'b00)
                || (w_dec_idx >= IDX_W'(NUM_REGS))
                || (w_dec_write && (w_dec_idx < IDX_W'(2)));

    always_comb begin
        w_rd_val = '0;
        if (w_dec_idx == IDX_W'(0)) begin
            w_rd_val = ID_VALUE;
        end else if (w_dec_idx == IDX_W'(1)) begin
            w_rd_val = r_counter;
        end else begin
            for (int i = 0; i < NUM_SCR; i++) begin
                if (w_dec_idx == IDX_W'(i + 2)) begin
                    w_rd_val = r_scratch[i];
                end
            end
        end
    end

    // Response registers are loaded on READY entry and cleared otherwise,
    // so PRDATA/PSLVERR are zero in every non-READY cycle.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
        end else begin
            r_prdata  <= (w_enter_ready && !w_err && !w_dec_write) ? w_rd_val : 32'd0;
            r_pslverr <= w_enter_ready && w_err;
        end
    end

    assign PREADY  = (r_state == S_READY);
    assign PRDATA  = r_prdata;
    assign PSLVERR = r_pslverr;

    // ------------------------------------------------------------------
    // Commit at the edge that ends READY. r_pslverr still holds this
    // transfer's error flag during READY.
    // ------------------------------------------------------------------
    assign w_commit = (r_state == S_READY) && PSEL && PENABLE && !r_pslverr;

    for (genvar gi = 0; gi < 4; gi++) begin : g_wmask
        assign w_wmask[8*gi +: 8] = {8{r_strb[gi]}};
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_counter <= '0;
            for (int i = 0; i < NUM_SCR; i++) begin
                r_scratch[i] <= '0;
            end
        end else if (w_commit) begin
            r_counter <= r_counter + 32'd1;
            if (r_write) begin
                for (int i = 0; i < NUM_SCR; i++) begin
                    if (w_wr_idx == IDX_W'(i + 2)) begin
                        r_scratch[i] <= (r_scratch[i] & ~w_wmask) | (r_wdata & w_wmask);
                    end
                end
            end
        end
    end

endmodule
